// File: rtl/pcm_decode_fsync_if.sv
// Bit-stream bundle between the bit synchroniser, the PCM decoder and the deformatter.
// Latency: none (wires only).
// Backpressure: none; the strobe-based stream cannot stall.
// Signals: bit_en_i/data_i carry raw bits into the decoder. dec_data_o/dec_valid_o
// carry decoded bits out. frame_start_o, sync_err_o, locked_o and state_o report
// frame-sync status. pol_inv_o exists only when PCM_AUTO_POLARITY_EN is defined.
interface pcm_decode_fsync_if;
  logic       bit_en_i;
  logic       data_i;
  logic       dec_data_o;
  logic       dec_valid_o;
  logic       frame_start_o;
  logic       sync_err_o;
  logic       locked_o;
  logic [1:0] state_o;
`ifdef PCM_AUTO_POLARITY_EN
  logic       pol_inv_o;

  modport master (
    output bit_en_i, data_i,
    input  dec_data_o, dec_valid_o, frame_start_o, sync_err_o, locked_o, state_o, pol_inv_o
  );
  modport slave (
    input  bit_en_i, data_i,
    output dec_data_o, dec_valid_o, frame_start_o, sync_err_o, locked_o, state_o, pol_inv_o
  );
`else
  modport master (
    output bit_en_i, data_i,
    input  dec_data_o, dec_valid_o, frame_start_o, sync_err_o, locked_o, state_o
  );
  modport slave (
    input  bit_en_i, data_i,
    output dec_data_o, dec_valid_o, frame_start_o, sync_err_o, locked_o, state_o
  );
`endif
endinterface

// File: rtl/pcm_decode_fsync.sv
// PCM bit decoder (RNRZ-L descrambler, NRZ-L/M/S) with frame-sync correlator and FSM.
// Latency: decoded bit 1 clk after bit_en_i; frame_start/sync_err 1 clk after dec_valid_o.
// Backpressure: none; one bit per strobe, idle cycles hold all state.
// Ports: clk_i, rst_n_i (async active-low), clr_i (sync clear); bus (slave modport)
// carries the raw bit strobe in and decoded bits/status out; pattern_i, invert_i,
// sync_word_i, err_tol_i, frame_len_i, verify_n_i and flywheel_n_i configure the block
// and are sampled live. Optional macro PCM_AUTO_POLARITY_EN adds complemented-sync
// detection in SEARCH and the pol_inv_o flag on the bus.
module pcm_decode_fsync #(
  parameter int                  LFSR_LEN  = 15,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = 15'h6000,
  parameter int                  SYNC_LEN  = 24,
  parameter int                  FLEN_W    = 16,
  parameter int                  CNT_W     = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  pcm_decode_fsync_if.slave   bus,
  input  logic [2:0]          pattern_i,
  input  logic                invert_i,
  input  logic [SYNC_LEN-1:0] sync_word_i,
  input  logic [5:0]          err_tol_i,
  input  logic [FLEN_W-1:0]   frame_len_i,
  input  logic [CNT_W-1:0]    verify_n_i,
  input  logic [CNT_W-1:0]    flywheel_n_i
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2,
    ST_FLY    = 2'd3
  } state_t;

  localparam logic [FLEN_W-1:0] FLEN_ONE   = FLEN_W'(1);
  localparam logic [FLEN_W-1:0] SYNC_LEN_F = FLEN_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  logic [LFSR_LEN-1:0] hist_q, hist_d;
  logic [SYNC_LEN-1:0] win_q, win_d;
  logic                dec_data_q, dec_data_d;
  logic                dec_valid_q, dec_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                sync_err_q, sync_err_d;
  logic                pol_inv_q, pol_inv_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    hits_q, hits_d;
  logic [CNT_W-1:0]    misses_q, misses_d;
  logic [FLEN_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic             tap_par, dec_raw, dec_bit;
  logic             match_n, match_c, len_ok, at_pos;
  logic [CNT_W-1:0] vn_eff, fn_eff, hits_inc, misses_inc;

  function automatic logic [7:0] popcnt(input logic [SYNC_LEN-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < SYNC_LEN; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  // Bit decode from the history as it stood before this strobe's shift.
  always_comb begin
    tap_par = ^(hist_q & LFSR_TAPS);
    case (pattern_i)
      3'd0:    dec_raw = bus.data_i ^ tap_par;
      3'd2:    dec_raw = hist_q[0] ^ bus.data_i;
      3'd3:    dec_raw = ~(hist_q[0] ^ bus.data_i);
      default: dec_raw = bus.data_i;
    endcase
    dec_bit = dec_raw ^ invert_i ^ pol_inv_q;
  end

  // The window already carries polarity-corrected bits, so the true word is
  // always the reference once pol_inv has been latched.
  assign match_n = popcnt(win_q ^ sync_word_i) <= {2'b00, err_tol_i};
`ifdef PCM_AUTO_POLARITY_EN
  assign match_c = popcnt(win_q ^ ~sync_word_i) <= {2'b00, err_tol_i};
`else
  assign match_c = 1'b0;
`endif

  assign len_ok     = frame_len_i > SYNC_LEN_F;
  assign at_pos     = bit_cnt_q == (frame_len_i - FLEN_ONE);
  assign vn_eff     = (verify_n_i == '0) ? CNT_ONE : verify_n_i;
  assign fn_eff     = (flywheel_n_i == '0) ? CNT_ONE : flywheel_n_i;
  assign hits_inc   = hits_q + CNT_ONE;
  assign misses_inc = misses_q + CNT_ONE;

  always_comb begin
    hist_d        = hist_q;
    win_d         = win_q;
    dec_data_d    = dec_data_q;
    dec_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    pol_inv_d     = pol_inv_q;
    state_d       = state_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    bit_cnt_d     = bit_cnt_q;

    if (clr_i) begin
      // Clear beats a coincident strobe: that bit is dropped.
      hist_d     = '0;
      win_d      = '0;
      dec_data_d = 1'b0;
      pol_inv_d  = 1'b0;
      state_d    = ST_SEARCH;
      hits_d     = '0;
      misses_d   = '0;
      bit_cnt_d  = '0;
    end else begin
      if (bus.bit_en_i) begin
        hist_d      = {hist_q[LFSR_LEN-2:0], bus.data_i};
        dec_data_d  = dec_bit;
        dec_valid_d = 1'b1;
        win_d       = {win_q[SYNC_LEN-2:0], dec_bit};
      end

      // Correlate the window that was loaded together with the current output bit.
      if (dec_valid_q) begin
        bit_cnt_d = bit_cnt_q + FLEN_ONE;
        case (state_q)
          ST_SEARCH: begin
            if (len_ok && (match_n || match_c)) begin
              state_d   = ST_VERIFY;
              hits_d    = CNT_ONE;
              bit_cnt_d = '0;
              pol_inv_d = !match_n;
            end
          end
          ST_VERIFY: begin
            if (at_pos) begin
              bit_cnt_d = '0;
              if (match_n) begin
                hits_d = hits_inc;
                if (hits_inc >= vn_eff) begin
                  state_d       = ST_LOCK;
                  frame_start_d = 1'b1;
                  misses_d      = '0;
                end
              end else begin
                state_d   = ST_SEARCH;
                hits_d    = '0;
                pol_inv_d = 1'b0;
              end
            end
          end
          ST_LOCK: begin
            if (at_pos) begin
              bit_cnt_d     = '0;
              frame_start_d = 1'b1;
              if (match_n) begin
                misses_d = '0;
              end else begin
                sync_err_d = 1'b1;
                misses_d   = CNT_ONE;
                state_d    = ST_FLY;
              end
            end
          end
          default: begin // ST_FLY
            if (at_pos) begin
              bit_cnt_d = '0;
              if (match_n) begin
                frame_start_d = 1'b1;
                misses_d      = '0;
                state_d       = ST_LOCK;
              end else begin
                sync_err_d = 1'b1;
                misses_d   = misses_inc;
                if (misses_inc >= fn_eff) begin
                  // Lock lost: no frame marker for this slot.
                  state_d   = ST_SEARCH;
                  hits_d    = '0;
                  misses_d  = '0;
                  pol_inv_d = 1'b0;
                end else begin
                  frame_start_d = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q        <= '0;
      win_q         <= '0;
      dec_data_q    <= 1'b0;
      dec_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      pol_inv_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      hits_q        <= '0;
      misses_q      <= '0;
      bit_cnt_q     <= '0;
    end else begin
      hist_q        <= hist_d;
      win_q         <= win_d;
      dec_data_q    <= dec_data_d;
      dec_valid_q   <= dec_valid_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      pol_inv_q     <= pol_inv_d;
      state_q       <= state_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      bit_cnt_q     <= bit_cnt_d;
    end
  end

  assign bus.dec_data_o    = dec_data_q;
  assign bus.dec_valid_o   = dec_valid_q;
  assign bus.frame_start_o = frame_start_q;
  assign bus.sync_err_o    = sync_err_q;
  assign bus.locked_o      = state_q[1];
  assign bus.state_o       = state_q;
`ifdef PCM_AUTO_POLARITY_EN
  assign bus.pol_inv_o     = pol_inv_q;
`endif

endmodule
